// File: rtl/bcd_pkg.sv
// Shared BCD constants and the load-saturation helper for the cascade counter.
package bcd_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

   function automatic logic [BCD_W-1:0] sat_digit(
      input logic [BCD_W-1:0] nibble,
      input logic [BCD_W-1:0] max
   );
      logic [BCD_W-1:0] res;
      if (nibble > max) begin
         res = max;
      end else begin
         res = nibble;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_cascade_counter_if.sv
// Control and value bus of the BCD cascade counter.
interface bcd_cascade_counter_if
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
);
   logic                      en;
   logic                      up;
   logic                      clear;
   logic                      load;
   logic [BCD_W*DIGITS-1:0]   load_value;
   logic [BCD_W*DIGITS-1:0]   out;
   logic                      step;
   logic                      wrap;

   modport master (
      output en, up, clear, load, load_value,
      input  out, step, wrap
   );

   modport slave (
      input  en, up, clear, load, load_value,
      output out, step, wrap
   );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit with programmable maximum; carry/borrow out when stepping past its limit.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [BCD_W-1:0] max,
   input  logic             step_in,
   input  logic             up,
   input  logic             load,
   input  logic [BCD_W-1:0] load_nibble,
   output logic [BCD_W-1:0] value,
   output logic             carry
);

   logic [BCD_W-1:0] value_r;
   logic [BCD_W-1:0] next_s;
   logic             at_limit_s;

   // Next digit value: clear > load > step, otherwise hold.
   always_comb begin
      next_s     = value_r;
      at_limit_s = up ? (value_r == max) : (value_r == 4'd0);
      if (clear) begin
         next_s = 4'd0;
      end else if (load) begin
         next_s = sat_digit(load_nibble, max);
      end else if (step_in) begin
         if (up) begin
            next_s = at_limit_s ? 4'd0 : value_r + 4'd1;
         end else begin
            next_s = at_limit_s ? max : value_r - 4'd1;
         end
      end else begin
         next_s = value_r;
      end
   end

   // Digit register, updated on the falling edge like the other time counters.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         value_r <= 4'd0;
      end else begin
         value_r <= next_s;
      end
   end

   assign value = value_r;
   assign carry = step_in && at_limit_s;

endmodule

// File: rtl/bcd_cascade_counter.sv
// Prescaled multi-digit BCD up/down counter with clear, saturating load and wrap flag.
module bcd_cascade_counter
   import bcd_pkg::*;
#(
   parameter int PRESCALE = 4,
   parameter int DIGITS   = 2,
   parameter int MSD_MAX  = 5
)
(
   input logic                  clk,
   input logic                  reset,
   bcd_cascade_counter_if.slave bus
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]             presc_r;
   logic [PW-1:0]             presc_next_s;
   logic                      step_edge_s;
   logic [DIGITS:0]           carry_s;
   logic [BCD_W*DIGITS-1:0]   value_s;
   logic                      step_r;
   logic                      wrap_r;

   assign step_edge_s = bus.en && (presc_r == PS_LAST) && !bus.clear && !bus.load;
   assign carry_s[0]  = step_edge_s;

   // Prescaler phase: restarts on clear/load, advances only while enabled.
   always_comb begin
      presc_next_s = presc_r;
      if (bus.clear || bus.load) begin
         presc_next_s = '0;
      end else if (bus.en) begin
         presc_next_s = (presc_r == PS_LAST) ? '0 : presc_r + PW'(1);
      end else begin
         presc_next_s = presc_r;
      end
   end

   // Prescaler and step/wrap pulse registers.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         presc_r <= '0;
         step_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         presc_r <= presc_next_s;
         step_r  <= step_edge_s;
         wrap_r  <= carry_s[DIGITS];
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      localparam logic [BCD_W-1:0] DMAX = (i == DIGITS - 1) ? BCD_W'(MSD_MAX) : DIGIT_MAX;

      bcd_digit u_digit (
         .clk         (clk),
         .reset       (reset),
         .clear       (bus.clear),
         .max         (DMAX),
         .step_in     (carry_s[i]),
         .up          (bus.up),
         .load        (bus.load),
         .load_nibble (bus.load_value[BCD_W*i +: BCD_W]),
         .value       (value_s[BCD_W*i +: BCD_W]),
         .carry       (carry_s[i+1])
      );
   end

   assign bus.out  = value_s;
   assign bus.step = step_r;
   assign bus.wrap = wrap_r;

endmodule
